// File: rtl/parity_monitor.sv
// RAM parity monitor for the raw-hits path: masks per-RAM parity flags, arms after a
// full FIFO write pass, latches error maps, counts error cycles, records the first error.
module parity_monitor #(
  parameter int MXCFEB  = 7,
  parameter int MXLY    = 6,
  parameter int MXRPC   = 5,
  parameter int MXMINI  = 2,
  parameter int ARM_CNT = 4097,
  parameter int CNTB    = 16,
  parameter int IDXB    = 6,
  localparam int NRAM   = MXCFEB*MXLY + MXRPC + MXMINI
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   perr_reset,
  input  logic [MXCFEB*MXLY-1:0] parity_err_cfeb,
  input  logic [MXRPC-1:0]       parity_err_rpc,
  input  logic [MXMINI-1:0]      parity_err_mini,
  input  logic [NRAM-1:0]        perr_mask,
  input  logic                   fifo_wen,
  output logic                   perr_en,
  output logic [MXCFEB-1:0]      perr_cfeb,
  output logic                   perr_rpc,
  output logic                   perr_mini,
  output logic                   perr,
  output logic                   perr_pulse,
  output logic [MXCFEB-1:0]      perr_cfeb_ff,
  output logic                   perr_rpc_ff,
  output logic                   perr_mini_ff,
  output logic                   perr_ff,
  output logic [NRAM-1:0]        perr_ram_ff,
  output logic [CNTB-1:0]        perr_cnt,
  output logic                   perr_first_vld,
  output logic [IDXB-1:0]        perr_first_ram,
  output logic [CNTB-1:0]        perr_first_time
);
  localparam int NCF = MXCFEB*MXLY;
  // One spare count above ARM_CNT: the counter may step once more on the arming edge.
  localparam int WB  = $clog2(ARM_CNT+2);
  localparam logic [CNTB-1:0] CMAX = '1;

  logic [NRAM-1:0] err_m;
  logic [IDXB-1:0] first_idx;
  logic [WB-1:0]   wadr_cnt;
  logic [CNTB-1:0] tcnt;
  logic            clr;

  assign err_m     = {parity_err_mini, parity_err_rpc, parity_err_cfeb} & ~perr_mask;
  assign perr_rpc  = |err_m[NCF +: MXRPC];
  assign perr_mini = |err_m[NCF+MXRPC +: MXMINI];
  assign perr      = |err_m;
  assign clr       = reset | perr_reset;

  for (genvar c = 0; c < MXCFEB; c++) begin : g_cfeb
    assign perr_cfeb[c] = |err_m[c*MXLY +: MXLY];
  end

  always_comb begin
    first_idx = '0;
    for (int i = NRAM-1; i >= 0; i--)
      if (err_m[i]) first_idx = IDXB'(i);
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      wadr_cnt        <= '0;
      perr_en         <= 1'b0;
      tcnt            <= '0;
      perr_pulse      <= 1'b0;
      perr_cfeb_ff    <= '0;
      perr_rpc_ff     <= 1'b0;
      perr_mini_ff    <= 1'b0;
      perr_ff         <= 1'b0;
      perr_ram_ff     <= '0;
      perr_cnt        <= '0;
      perr_first_vld  <= 1'b0;
      perr_first_ram  <= '0;
      perr_first_time <= '0;
    end else begin
      wadr_cnt   <= (fifo_wen && !perr_en) ? wadr_cnt + 1'b1 : '0;
      perr_pulse <= perr & perr_en;
      if (wadr_cnt == WB'(ARM_CNT)) perr_en <= 1'b1;
      if (perr_en) begin
        perr_cfeb_ff <= perr_cfeb_ff | perr_cfeb;
        perr_rpc_ff  <= perr_rpc_ff  | perr_rpc;
        perr_mini_ff <= perr_mini_ff | perr_mini;
        perr_ff      <= perr_ff      | perr;
        perr_ram_ff  <= perr_ram_ff  | err_m;
        if (tcnt != CMAX) tcnt <= tcnt + 1'b1;
        if (perr && perr_cnt != CMAX) perr_cnt <= perr_cnt + 1'b1;
        if (perr && !perr_first_vld) begin
          perr_first_vld  <= 1'b1;
          perr_first_ram  <= first_idx;
          perr_first_time <= tcnt;
        end
      end else begin
        tcnt        <= '0;
        perr_ram_ff <= '0;
      end
    end
  end
endmodule

// File: tb/tb_parity_monitor.sv
// Randomized + directed check of parity_monitor against a cycle-level behavioural model.
module tb_parity_monitor;
  localparam int ARM = 8;
  localparam int CB  = 4;
  localparam int NR  = 49;
  localparam int CMX = (1 << CB) - 1;

  logic clock = 0, reset = 0, perr_reset = 0, fifo_wen = 0;
  logic [41:0] cf = '0;
  logic [4:0]  rp = '0;
  logic [1:0]  mn = '0;
  logic [NR-1:0] mask = '0;
  logic perr_en, perr_rpc, perr_mini, perr, perr_pulse;
  logic perr_rpc_ff, perr_mini_ff, perr_ff, perr_first_vld;
  logic [6:0] perr_cfeb, perr_cfeb_ff;
  logic [NR-1:0] perr_ram_ff;
  logic [CB-1:0] perr_cnt, perr_first_time;
  logic [5:0] perr_first_ram;

  parity_monitor #(.ARM_CNT(ARM), .CNTB(CB)) dut (
    .clock(clock), .reset(reset), .perr_reset(perr_reset),
    .parity_err_cfeb(cf), .parity_err_rpc(rp), .parity_err_mini(mn),
    .perr_mask(mask), .fifo_wen(fifo_wen), .perr_en(perr_en),
    .perr_cfeb(perr_cfeb), .perr_rpc(perr_rpc), .perr_mini(perr_mini), .perr(perr),
    .perr_pulse(perr_pulse), .perr_cfeb_ff(perr_cfeb_ff), .perr_rpc_ff(perr_rpc_ff),
    .perr_mini_ff(perr_mini_ff), .perr_ff(perr_ff), .perr_ram_ff(perr_ram_ff),
    .perr_cnt(perr_cnt), .perr_first_vld(perr_first_vld),
    .perr_first_ram(perr_first_ram), .perr_first_time(perr_first_time));

  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0;

  // behavioural model state
  bit m_en, m_pulse, m_rpc_ff, m_mini_ff, m_perr_ff, m_fv;
  int m_run, m_t, m_cnt, m_fr, m_ft;
  logic [NR-1:0] m_ram;
  logic [6:0]    m_cfeb_ff;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [6:0] cfeb_or(input logic [NR-1:0] e);
    logic [6:0] r = '0;
    for (int i = 0; i < 42; i++) if (e[i]) r[i/6] = 1'b1;
    return r;
  endfunction

  function automatic bit any_in(input logic [NR-1:0] e, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) if (e[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    m_en = 0; m_pulse = 0; m_rpc_ff = 0; m_mini_ff = 0; m_perr_ff = 0; m_fv = 0;
    m_run = 0; m_t = 0; m_cnt = 0; m_fr = 0; m_ft = 0; m_ram = '0; m_cfeb_ff = '0;
  endtask

  task automatic step(input logic [41:0] c, input logic [4:0] r, input logic [1:0] m,
                      input logic wen, input logic prst);
    logic [NR-1:0] e;
    cf = c; rp = r; mn = m; fifo_wen = wen; perr_reset = prst;
    @(negedge clock);
    e = {m, r, c} & ~mask;
    chk("perr_cfeb", perr_cfeb, cfeb_or(e));
    chk("perr_rpc",  perr_rpc,  any_in(e, 42, 46));
    chk("perr_mini", perr_mini, any_in(e, 47, 48));
    chk("perr",      perr,      e != '0);
    if (reset || prst) model_clear();
    else if (m_en) begin
      m_pulse = (e != '0);
      if (e != '0) begin
        m_cnt = (m_cnt < CMX) ? m_cnt + 1 : CMX;
        if (!m_fv) begin
          m_fv = 1; m_ft = m_t;
          for (int i = NR-1; i >= 0; i--) if (e[i]) m_fr = i;
        end
      end
      m_ram |= e; m_cfeb_ff |= cfeb_or(e);
      m_rpc_ff |= any_in(e, 42, 46); m_mini_ff |= any_in(e, 47, 48); m_perr_ff |= (e != '0);
      m_t = (m_t < CMX) ? m_t + 1 : CMX;
    end else begin
      m_pulse = 0; m_t = 0;
      if (m_run == ARM) m_en = 1;
      m_run = wen ? m_run + 1 : 0;
    end
    @(posedge clock); #1;
    chk("perr_en",      perr_en,         m_en);
    chk("perr_pulse",   perr_pulse,      m_pulse);
    chk("perr_cfeb_ff", perr_cfeb_ff,    m_cfeb_ff);
    chk("perr_rpc_ff",  perr_rpc_ff,     m_rpc_ff);
    chk("perr_mini_ff", perr_mini_ff,    m_mini_ff);
    chk("perr_ff",      perr_ff,         m_perr_ff);
    chk("perr_ram_ff",  perr_ram_ff,     m_ram);
    chk("perr_cnt",     perr_cnt,        m_cnt);
    chk("first_vld",    perr_first_vld,  m_fv);
    chk("first_ram",    perr_first_ram,  m_fr);
    chk("first_time",   perr_first_time, m_ft);
  endtask

  task automatic idle(input int n, input logic wen);
    for (int i = 0; i < n; i++) step('0, '0, '0, wen, 1'b0);
  endtask

  initial begin
    logic [41:0] one42;
    logic [NR-1:0] rm;
    one42 = 42'd1;
    model_clear();
    reset = 1; idle(2, 0); reset = 0;
    // arming with a gap; an unarmed error on CFEB1 layer 1 in the first burst
    step('0, '0, '0, 1, 0);
    step(one42 << 7, '0, '0, 1, 0);
    chk("unarmed_cnt", perr_cnt, 0);
    chk("unarmed_ram", perr_ram_ff, 0);
    idle(3, 1);
    idle(1, 0);
    chk("gap_en", perr_en, 0);
    idle(9, 1);
    chk("armed", perr_en, 1);
    // masked RAM 3 plus RPC RAM 44, four cycles after arming
    idle(4, 0);
    mask = 49'd1 << 3;
    step(one42 << 3, 5'd1 << 2, '0, 0, 0);
    chk("mask_ram", perr_ram_ff, 49'd1 << 44);
    chk("mask_rpc", perr_rpc_ff, 1);
    chk("mask_first", perr_first_ram, 44);
    chk("mask_time", perr_first_time, 4);
    chk("mask_cnt", perr_cnt, 1);
    chk("mask_cfeb", perr_cfeb_ff, 0);
    mask = '0;
    // clear in the middle of an error, then re-arm
    step(one42 << 20, '0, '0, 0, 0);
    step(one42 << 20, '0, '0, 1, 1);
    chk("clr_en", perr_en, 0);
    chk("clr_cnt", perr_cnt, 0);
    chk("clr_vld", perr_first_vld, 0);
    idle(8, 1);
    chk("rearm_early", perr_en, 0);
    idle(1, 1);
    chk("rearm", perr_en, 1);
    // RAMs 13 and 47 together, then RAM 2 later
    idle(2, 0);
    step(one42 << 13, '0, 2'b01, 0, 0);
    chk("lowest", perr_first_ram, 13);
    idle(1, 0);
    step(one42 << 2, '0, '0, 0, 0);
    chk("first_hold", perr_first_ram, 13);
    chk("ram2", perr_ram_ff[2], 1);
    // long error: counter saturates
    for (int i = 0; i < 20; i++) step(one42 << 30, '0, '0, 0, 0);
    chk("sat", perr_cnt, CMX);
    idle(1, 0);
    // random phase
    for (int n = 0; n < 4000; n++) begin
      logic [41:0] c; logic [4:0] r; logic [1:0] m;
      c = '0; r = '0; m = '0;
      if ($urandom_range(7) == 0) c = one42 << $urandom_range(41);
      if ($urandom_range(15) == 0) c |= one42 << $urandom_range(41);
      if ($urandom_range(15) == 0) r = 5'd1 << $urandom_range(4);
      if ($urandom_range(15) == 0) m = 2'd1 << $urandom_range(1);
      if ($urandom_range(99) == 0) begin
        rm = {$urandom, $urandom};
        mask = ($urandom_range(1) == 0) ? '0 : rm & {$urandom, $urandom} & {$urandom, $urandom};
      end
      step(c, r, m, $urandom_range(9) != 0, $urandom_range(399) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/parity_monitor.md
# parity_monitor

Parametrised RAM parity monitor for the TMB raw-hits path. It collects per-RAM parity error flags from the CFEB, RPC and miniscope RAMs, applies a per-RAM mask, and arms only after the raw-hits FIFO has written every address. It latches per-source and per-RAM error maps, counts error cycles with saturation, and captures the identity and time of the first error for VME readout. Its summary outputs drive the sequencer and the VME status registers.

## Interface
Parameters:
- MXCFEB, 7, number of CFEBs
- MXLY, 6, layers (RAMs) per CFEB
- MXRPC, 5, RPC RAMs
- MXMINI, 2, miniscope RAMs
- ARM_CNT, 4097, consecutive fifo_wen cycles required before arming
- CNTB, 16, width of error counter and timestamp
- IDXB, 6, width of RAM index; must satisfy 2^IDXB >= NRAM
- NRAM (derived), MXCFEB*MXLY+MXRPC+MXMINI (default 49)

RAM index map:
- CFEB c, layer l → c*MXLY+l
- RPC r → MXCFEB*MXLY+r
- mini m → MXCFEB*MXLY+MXRPC+m

Ports (clock and reset first):
- clock  in  1  40 MHz TMB main clock
- reset  in  1  synchronous, active-high; clock clock
- perr_reset  in  1  VME parity-error reset, synchronous, same effect as reset
- parity_err_cfeb  in  MXCFEB*MXLY  CFEB RAM errors, bit = RAM index
- parity_err_rpc  in  MXRPC  RPC RAM errors
- parity_err_mini  in  MXMINI  miniscope RAM errors
- perr_mask  in  NRAM  1 = ignore that RAM, quasi-static
- fifo_wen  in  1  raw-hits FIFO write enable
- perr_en  out  1  monitor armed
- perr_cfeb  out  MXCFEB  per-CFEB masked error, combinational
- perr_rpc, perr_mini, perr  out  1  masked summaries, combinational
- perr_pulse  out  1  registered perr & perr_en
- perr_cfeb_ff, perr_rpc_ff, perr_mini_ff, perr_ff  out  MXCFEB/1/1/1  latched summaries
- perr_ram_ff  out  NRAM  latched per-RAM error map
- perr_cnt  out  CNTB  saturating count of error cycles
- perr_first_vld  out  1  first error captured
- perr_first_ram  out  IDXB  lowest RAM index erroring at first error
- perr_first_time  out  CNTB  cycles from arming to first error

## Operation
- Error input: err_m = {mini, rpc, cfeb} & ~perr_mask. All summaries are ORs over the relevant slice of err_m.
- Arming: wadr_cnt increments on each clock with fifo_wen && !perr_en and clears to 0 on any other clock. perr_en sets on the edge where wadr_cnt == ARM_CNT. Once set, perr_en stays high until reset or perr_reset. A fifo_wen gap restarts the count from 0.
- Latching (only while perr_en): each *_ff |= its combinational counterpart; perr_ram_ff |= err_m.
  - perr_ram_ff is held at 0 whenever !perr_en.
- perr_cnt: +1 on each clock with perr && perr_en; holds at 2^CNTB-1.
- Timestamp: tcnt clears while !perr_en, increments each cycle while perr_en, and saturates at 2^CNTB-1.
- First-error capture: on the first clock with perr && perr_en && !perr_first_vld:
  - perr_first_vld <= 1
  - perr_first_ram <= lowest set index of err_m
  - perr_first_time <= tcnt
  - These hold until reset.
- Clear: reset or perr_reset, sampled at the same edge, zeroes every register, including perr_en and wadr_cnt. The monitor must then re-arm. Clear wins over any simultaneous error or arming condition.

## Timing
- Reset value of every registered output is 0. Combinational outputs follow their inputs with 0 latency.
- perr_en rises ARM_CNT+1 edges after the first of ARM_CNT+1 consecutive fifo_wen cycles.
- Error at cycle N while perr_en is high:
  - perr_pulse, *_ff, perr_ram_ff, perr_cnt and first-capture update at edge N+1.
- tcnt is 0 in the first perr_en cycle. An error in that cycle captures perr_first_time = 0.
- Errors while !perr_en produce no pulse, no count and no latch.
- Mask changes take effect in the same cycle.

## Test plan
- ARM_CNT=8: fifo_wen high 5 cycles, low 1 cycle, then high 9 cycles. Required: perr_en = 0 after the gap; perr_en = 1 after the 9th edge of the second burst.
- Unarmed: parity_err_cfeb bit 7 pulsed before perr_en. Required: perr_cfeb[1]=1 combinationally; perr_pulse=0; perr_ram_ff=0; perr_cnt=0.
- Armed, mask bit 3 set: pulse RAMs 3 and 44 in the same cycle, 4 cycles after arming. Required: perr_ram_ff = 1<<44; perr_rpc_ff=1; perr_first_ram=44; perr_first_time=4; perr_cnt=1; perr_cfeb_ff=0.
- Simultaneous RAMs 13 and 47. Required: perr_first_ram=13. A later error on RAM 2 leaves perr_first_ram at 13 and sets perr_ram_ff[2].
- CNTB=4: hold an error for 20 cycles. Required: perr_cnt=15 with no wrap; perr_pulse high for 20 cycles.
- perr_reset mid-error while perr_en=1. Required: all outputs 0 on the next edge; perr_en stays 0 until another ARM_CNT+1 fifo_wen cycles complete.
